// File: rtl/branch_predictor.sv
// Gshare branch-direction predictor: a table of 2-bit saturating counters indexed by
// PC XOR global history, trained by resolved branches, with branch/mispredict statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           fetch_pc_i,
    output logic                  predict_taken_o,
    output logic [INDEX_BITS-1:0] predict_index_o,
    input  logic                  update_valid_i,
    input  logic [INDEX_BITS-1:0] update_index_i,
    input  logic                  update_taken_i,
    input  logic                  update_predicted_i,
    output logic [31:0]           branch_count_o,
    output logic [31:0]           mispredict_count_o
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]            r_table [DEPTH];
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    logic [INDEX_BITS-1:0] w_hist_ext;
    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_cur_ctr;
    logic [1:0]            w_next_ctr;
    logic                  w_unused_pc_bits;

    // Word-aligned PC bits only; the rest of the PC never influences the index.
    assign w_unused_pc_bits = ^{fetch_pc_i[31:INDEX_BITS+2], fetch_pc_i[1:0]};

    generate
        if (HIST_BITS == 0) begin : g_no_hist
            assign w_hist_ext = '0;
        end else begin : g_hist
            logic [HIST_BITS-1:0] r_ghr;

            // History tracks resolved branches only, so fetch never touches it.
            if (HIST_BITS == 1) begin : g_one
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_ghr <= '0;
                    end else if (update_valid_i) begin
                        r_ghr <= update_taken_i;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_ghr <= '0;
                    end else if (update_valid_i) begin
                        r_ghr <= {r_ghr[HIST_BITS-2:0], update_taken_i};
                    end
                end
            end

            assign w_hist_ext = INDEX_BITS'(r_ghr);
        end
    endgenerate

    assign w_index         = fetch_pc_i[INDEX_BITS+1:2] ^ w_hist_ext;
    assign predict_index_o = w_index;
    // Reads the registered table directly: a same-cycle update is not bypassed.
    assign predict_taken_o = r_table[w_index][1];

    assign w_cur_ctr = r_table[update_index_i];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_next_ctr = w_cur_ctr;
        if (update_taken_i) begin
            if (w_cur_ctr != 2'b11) begin
                w_next_ctr = w_cur_ctr + 2'b01;
            end
        end else begin
            if (w_cur_ctr != 2'b00) begin
                w_next_ctr = w_cur_ctr - 2'b01;
            end
        end
    end

    // NOTE: the table is built from flops and is reset entry by entry, because every counter must restart at weak-not-taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (update_valid_i) begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
            r_table[update_index_i] <= w_next_ctr;
        end
    end

    // Statistics trust update_predicted_i; both counters wrap modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (update_valid_i) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (update_taken_i != update_predicted_i) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count_o     = r_branch_count;
    assign mispredict_count_o = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a bimodal instance (HIST_BITS=0) and a gshare
// instance (HIST_BITS=2); stimulus queues expected outputs, a negedge monitor compares them.
module tb_branch_predictor;

    typedef enum int { F_PT, F_PI, F_BC, F_MC } fld_e;

    typedef struct {
        int    sel;
        fld_e  fld;
        logic [31:0] val;
        string name;
    } exp_t;

    logic        clk;

    logic        b_rst, g_rst;
    logic [31:0] b_pc, g_pc;
    logic        b_pt, g_pt;
    logic [5:0]  b_pi, g_pi;
    logic        b_uv, g_uv;
    logic [5:0]  b_ui, g_ui;
    logic        b_ut, g_ut;
    logic        b_up, g_up;
    logic [31:0] b_bc, g_bc;
    logic [31:0] b_mc, g_mc;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    branch_predictor #(.INDEX_BITS(6), .HIST_BITS(0)) u_bim (
        .clk_i              (clk),
        .rst_i              (b_rst),
        .fetch_pc_i         (b_pc),
        .predict_taken_o    (b_pt),
        .predict_index_o    (b_pi),
        .update_valid_i     (b_uv),
        .update_index_i     (b_ui),
        .update_taken_i     (b_ut),
        .update_predicted_i (b_up),
        .branch_count_o     (b_bc),
        .mispredict_count_o (b_mc)
    );

    branch_predictor #(.INDEX_BITS(6), .HIST_BITS(2)) u_gs (
        .clk_i              (clk),
        .rst_i              (g_rst),
        .fetch_pc_i         (g_pc),
        .predict_taken_o    (g_pt),
        .predict_index_o    (g_pi),
        .update_valid_i     (g_uv),
        .update_index_i     (g_ui),
        .update_taken_i     (g_ut),
        .update_predicted_i (g_up),
        .branch_count_o     (g_bc),
        .mispredict_count_o (g_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic [31:0] pc, input logic uv, input logic [5:0] ui,
                         input logic ut, input logic up);
        b_pc = pc; b_uv = uv; b_ui = ui; b_ut = ut; b_up = up;
    endtask

    task automatic set_g(input logic [31:0] pc, input logic uv, input logic [5:0] ui,
                         input logic ut, input logic up);
        g_pc = pc; g_uv = uv; g_ui = ui; g_ut = ut; g_up = up;
    endtask

    task automatic push_exp(input int sel, input fld_e fld, input logic [31:0] val,
                            input string name);
        exp_t e;
        e.sel = sel; e.fld = fld; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int sel, input fld_e fld);
        logic [31:0] v;
        v = '0;
        case (fld)
            F_PT: v = (sel == 0) ? 32'(b_pt) : 32'(g_pt);
            F_PI: v = (sel == 0) ? 32'(b_pi) : 32'(g_pi);
            F_BC: v = (sel == 0) ? b_bc : g_bc;
            F_MC: v = (sel == 0) ? b_mc : g_mc;
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: drains every expectation queued for this cycle, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, actual(e.sel, e.fld), e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        b_rst = 1'b1; g_rst = 1'b1;
        set_b(32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        set_g(32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        b_rst = 1'b0; g_rst = 1'b0;

        // Reset state: no PC predicts taken, index is PC[7:2], counters cleared.
        push_exp(0, F_BC, 32'd0, "rst_bim_bc");
        push_exp(0, F_MC, 32'd0, "rst_bim_mc");
        push_exp(1, F_BC, 32'd0, "rst_gs_bc");
        push_exp(1, F_MC, 32'd0, "rst_gs_mc");
        for (int pc = 0; pc <= 32'h100; pc += 4) begin
            set_b(32'(pc), 1'b0, 6'd0, 1'b0, 1'b0);
            set_g(32'(pc), 1'b0, 6'd0, 1'b0, 1'b0);
            push_exp(0, F_PT, 32'd0, "sweep_bim_pt");
            push_exp(0, F_PI, 32'((pc >> 2) & 63), "sweep_bim_pi");
            push_exp(1, F_PT, 32'd0, "sweep_gs_pt");
            push_exp(1, F_PI, 32'((pc >> 2) & 63), "sweep_gs_pi");
            step();
        end

        // Bimodal training on PC 0x40 (index 16); first cycle is also read-during-write.
        set_b(32'h40, 1'b1, 6'd16, 1'b1, 1'b0); push_exp(0, F_PT, 32'd0, "rdw_same_cycle"); step();
        set_b(32'h40, 1'b1, 6'd16, 1'b1, 1'b0); push_exp(0, F_PT, 32'd1, "rdw_next_cycle"); step();
        set_b(32'h40, 1'b1, 6'd16, 1'b1, 1'b1); push_exp(0, F_PT, 32'd1, "train_11");       step();
        set_b(32'h40, 1'b1, 6'd16, 1'b0, 1'b1); push_exp(0, F_PT, 32'd1, "saturated_11");   step();
        set_b(32'h40, 1'b0, 6'd0,  1'b0, 1'b0); push_exp(0, F_PT, 32'd1, "one_nt_10");      step();
        set_b(32'h40, 1'b1, 6'd16, 1'b0, 1'b1); push_exp(0, F_PT, 32'd1, "pre_second_nt");  step();
        set_b(32'h40, 1'b0, 6'd0,  1'b0, 1'b0);
        push_exp(0, F_PT, 32'd0, "two_nt_01");
        push_exp(0, F_BC, 32'd5, "train_bc");
        push_exp(0, F_MC, 32'd4, "train_mc");
        step();

        // Statistics: 10 updates, mispredicts at i = 2, 5, 7.
        b_rst = 1'b1; step(); b_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic t;
            t = 1'(i & 1);
            set_b(32'h0, 1'b1, 6'(i + 20), t, (i == 2 || i == 5 || i == 7) ? ~t : t);
            step();
        end
        set_b(32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        push_exp(0, F_BC, 32'd10, "stats_bc");
        push_exp(0, F_MC, 32'd3, "stats_mc");
        step();

        // Wrap: preload both counters to all-ones, one mispredicted update wraps both to 0.
        force u_bim.r_branch_count = 32'hFFFF_FFFF;
        force u_bim.r_mispredict_count = 32'hFFFF_FFFF;
        set_b(32'h0, 1'b1, 6'd30, 1'b1, 1'b0);
        #1;
        release u_bim.r_branch_count;
        release u_bim.r_mispredict_count;
        step();
        set_b(32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        push_exp(0, F_BC, 32'd0, "wrap_bc");
        push_exp(0, F_MC, 32'd0, "wrap_mc");
        step();

        // Reset with a simultaneous update: the update is discarded.
        b_rst = 1'b1;
        set_b(32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
        step();
        b_rst = 1'b0;
        push_exp(0, F_PT, 32'd0, "rst_upd_pt");
        push_exp(0, F_BC, 32'd0, "rst_upd_bc");
        push_exp(0, F_MC, 32'd0, "rst_upd_mc");
        step();
        set_b(32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
        push_exp(0, F_PT, 32'd1, "rst_upd_ctr_was_01");
        push_exp(0, F_BC, 32'd1, "rst_upd_bc1");
        step();

        // Gshare: history shifts in resolved outcomes and XORs into the index.
        set_g(32'h0,  1'b1, 6'd0, 1'b1, 1'b0); push_exp(1, F_PI, 32'h00, "gs_idx_ghr00"); step();
        set_g(32'h40, 1'b1, 6'd0, 1'b1, 1'b0); push_exp(1, F_PI, 32'h11, "gs_idx_ghr01"); step();
        set_g(32'h40, 1'b1, 6'd0, 1'b1, 1'b0);
        push_exp(1, F_PI, 32'h13, "gs_idx_ghr11");
        push_exp(1, F_PT, 32'd0, "gs_pt_0x13");
        step();
        set_g(32'h40, 1'b1, 6'd0, 1'b0, 1'b0); push_exp(1, F_PI, 32'h13, "gs_idx_ghr11_sat"); step();
        set_g(32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        push_exp(1, F_PI, 32'h12, "gs_idx_ghr10");
        push_exp(1, F_BC, 32'd4, "gs_bc");
        push_exp(1, F_MC, 32'd3, "gs_mc");
        step();

        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch-direction predictor for the RV32 core. It holds a table of 2-bit saturating counters, indexed gshare-style by PC and global history. At fetch it returns a taken/not-taken guess plus the table index used. When the branch resolves, it is trained with the real outcome from the branch-condition logic (beq/bne/blt/bge decision). It also keeps branch and mispredict statistics counters.

## Interface

Parameters:
- INDEX_BITS, 6, log2 of table depth (64 entries); legal 2..10
- HIST_BITS, 4, global history length; legal 0..INDEX_BITS; 0 = pure bimodal

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- fetch_pc_i  input  32  PC of instruction being fetched
- predict_taken_o  output  1  predicted direction for fetch_pc_i (combinational)
- predict_index_o  output  INDEX_BITS  table index used for the prediction; carried with the instruction
- update_valid_i  input  1  a conditional branch resolved this cycle
- update_index_i  input  INDEX_BITS  predict_index_o value captured at that branch's fetch
- update_taken_i  input  1  resolved outcome (branch-condition taken)
- update_predicted_i  input  1  predict_taken_o value captured at that branch's fetch
- branch_count_o  output  32  resolved branches since reset
- mispredict_count_o  output  32  resolved branches with taken != predicted

## Operation

- Table: 2^INDEX_BITS entries of 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- GHR: HIST_BITS-bit shift register; newest outcome in bit 0.
- Index: fetch_pc_i[INDEX_BITS+1:2] XOR zero-extended GHR. HIST_BITS=0: index = PC bits only.
- predict_index_o is that index.
- predict_taken_o = table[index][1].
- Update, when update_valid_i = 1:
  - Train table[update_index_i]: taken increments, saturating at 11; not-taken decrements, saturating at 00.
  - GHR <= {GHR[HIST_BITS-2:0], update_taken_i}.
  - branch_count_o += 1.
  - mispredict_count_o += 1 iff update_taken_i != update_predicted_i.
- update_valid_i = 0: no state changes; update_index_i, update_taken_i and update_predicted_i are ignored.
- Both statistics counters wrap modulo 2^32 (FFFF_FFFF + 1 -> 0000_0000).
- The predictor never modifies counters based on fetch alone. Training is non-speculative, so the GHR reflects resolved branches only.
- The block does not check update_predicted_i against the table. The statistics trust the caller.

## Timing

- Prediction path is purely combinational from fetch_pc_i, the table and the GHR. Zero-cycle latency, suited to the single-cycle datapath.
- Training is visible one cycle later: a fetch in the cycle after the update edge sees the new counter and GHR.
- Same-cycle fetch and update to the same index: predict_taken_o reflects the pre-update counter. There is no bypass.
- Reset (rst_i = 1 at a rising edge) has priority over any simultaneous update, and an in-flight update is discarded. After reset:
  - all counters = 01
  - GHR = 0
  - branch_count_o = 0, mispredict_count_o = 0
  - predict_taken_o = 0 for every PC
- Outputs are valid from the first edge after reset deasserts.
- No handshakes and no backpressure: every update is accepted in the cycle presented.

## Test plan

- Reset: hold rst_i 1 cycle, then sweep fetch_pc_i over 0x0..0x100 -> predict_taken_o = 0 everywhere, both counters = 0.
- Bimodal training (HIST_BITS=0): two updates taken at index of PC 0x40 -> predict 1. A third taken saturates at 11. One not-taken -> still 1 (10). A second not-taken -> 0.
- Gshare aliasing (HIST_BITS=2): resolve taken, taken -> GHR = 11. Fetch PC 0x40 -> predict_index_o = 0x10 ^ 0x3 = 0x13.
- Statistics: 10 updates with 3 where taken != predicted -> branch_count_o = 10, mispredict_count_o = 3. Preload via 2^32-1 updates (or force) -> next update wraps to 0.
- Read-during-write: same-cycle fetch and update on a counter at 01 with taken -> predict_taken_o = 0 that cycle, 1 the next.
- Reset mid-training: rst_i asserted in the same cycle as update_valid_i -> counter stays 01, branch_count_o = 0.
